// File: rtl/snake_body_ctrl.sv
`timescale 1ns/1ps
// snake_body_ctrl: snake segment list with a move/grow/collide FSM and a registered pixel classifier.
// Define SNAKE_WRAP_EN for a wrap-around playfield with no walls, where only self collision kills.
module snake_body_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 30,
    parameter int GRID_H   = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_tick,
    input  logic [1:0]  dir,
    input  logic [5:0]  apple_x,
    input  logic [4:0]  apple_y,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    output logic [1:0]  snake,
    output logic        eat,
    output logic        dead,
    output logic [4:0]  len,
    output logic [5:0]  head_x,
    output logic [4:0]  head_y
);
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam logic [1:0]  DIR_UP    = 2'b00;
    localparam logic [1:0]  DIR_DOWN  = 2'b01;
    localparam logic [1:0]  DIR_LEFT  = 2'b10;
    localparam logic [1:0]  DIR_RIGHT = 2'b11;
    localparam logic [1:0]  CLS_NONE  = 2'b00;
    localparam logic [1:0]  CLS_HEAD  = 2'b01;
    localparam logic [1:0]  CLS_BODY  = 2'b10;
    localparam logic [1:0]  CLS_WALL  = 2'b11;
    localparam logic [5:0]  X_LAST    = 6'(GRID_W - 1);
    localparam logic [4:0]  Y_LAST    = 5'(GRID_H - 1);
    localparam logic [4:0]  LEN_INIT  = 5'(INIT_LEN);
    localparam logic [4:0]  LEN_MAX   = 5'(MAX_LEN);
    localparam logic [11:0] PIX_W     = 12'(GRID_W * 16);
    localparam logic [11:0] PIX_H     = 12'(GRID_H * 16);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t     state_q, state_d;
    logic [5:0] seg_x_q [MAX_LEN];
    logic [5:0] seg_x_d [MAX_LEN];
    logic [4:0] seg_y_q [MAX_LEN];
    logic [4:0] seg_y_d [MAX_LEN];
    logic [4:0] len_q, len_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic       eat_q, eat_d;
    logic       dead_q, dead_d;
    logic [1:0] snake_q, snake_d;

    logic [1:0] new_dir;
    logic [5:0] next_x;
    logic [4:0] next_y;
    logic       grow;
    logic       hit_wall;
    logic       hit_self;
    logic [5:0] cell_x;
    logic [4:0] cell_y;

    function automatic logic is_border(input logic [5:0] cx, input logic [4:0] cy);
        return (cx == 6'd0) || (cx == X_LAST) || (cy == 5'd0) || (cy == Y_LAST);
    endfunction

    function automatic logic [5:0] init_x(input int i);
        return (i < INIT_LEN) ? 6'(8 - i) : 6'd0;
    endfunction

    function automatic logic [4:0] init_y(input int i);
        return (i < INIT_LEN) ? 5'd8 : 5'd0;
    endfunction

    // The tail vacates its cell on a plain move, so it only blocks the head when growing.
    always_comb begin
        new_dir = (dir == (cur_dir_q ^ 2'b01)) ? cur_dir_q : dir;
        next_x  = seg_x_q[0];
        next_y  = seg_y_q[0];
        case (new_dir)
            DIR_UP:    next_y = (WRAP_EN && seg_y_q[0] == 5'd0)   ? Y_LAST : seg_y_q[0] - 5'd1;
            DIR_DOWN:  next_y = (WRAP_EN && seg_y_q[0] == Y_LAST) ? 5'd0   : seg_y_q[0] + 5'd1;
            DIR_LEFT:  next_x = (WRAP_EN && seg_x_q[0] == 6'd0)   ? X_LAST : seg_x_q[0] - 6'd1;
            default:   next_x = (WRAP_EN && seg_x_q[0] == X_LAST) ? 6'd0   : seg_x_q[0] + 6'd1;
        endcase
        grow     = (next_x == apple_x) && (next_y == apple_y);
        hit_wall = !WRAP_EN && is_border(next_x, next_y);
        hit_self = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((5'(i) + 5'd1 < len_q) || (grow && (5'(i) + 5'd1 == len_q))) &&
                (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y)) begin
                hit_self = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        seg_x_d   = seg_x_q;
        seg_y_d   = seg_y_q;
        len_d     = len_q;
        cur_dir_d = cur_dir_q;
        eat_d     = 1'b0;
        dead_d    = dead_q;
        if (start) begin
            state_d   = RUN;
            dead_d    = 1'b0;
            len_d     = LEN_INIT;
            cur_dir_d = DIR_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = init_y(i);
            end
        end else if (state_q == RUN && move_tick) begin
            if (hit_wall || hit_self) begin
                state_d = DEAD;
                dead_d  = 1'b1;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = next_x;
                seg_y_d[0] = next_y;
                cur_dir_d  = new_dir;
                eat_d      = grow;
                if (grow && len_q < LEN_MAX) begin
                    len_d = len_q + 5'd1;
                end
            end
        end
    end

    // Lookup runs against the registered (pre-move) segments.
    always_comb begin
        cell_x  = x_pos[9:4];
        cell_y  = y_pos[8:4];
        snake_d = CLS_NONE;
        if (x_pos < PIX_W && y_pos < PIX_H) begin
            if (!WRAP_EN && is_border(cell_x, cell_y)) begin
                snake_d = CLS_WALL;
            end else if (cell_x == seg_x_q[0] && cell_y == seg_y_q[0]) begin
                snake_d = CLS_HEAD;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    if (5'(i) < len_q && cell_x == seg_x_q[i] && cell_y == seg_y_q[i]) begin
                        snake_d = CLS_BODY;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= LEN_INIT;
            cur_dir_q <= DIR_RIGHT;
            eat_q     <= 1'b0;
            dead_q    <= 1'b0;
            snake_q   <= CLS_NONE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cur_dir_q <= cur_dir_d;
            eat_q     <= eat_d;
            dead_q    <= dead_d;
            snake_q   <= snake_d;
            seg_x_q   <= seg_x_d;
            seg_y_q   <= seg_y_d;
        end
    end

    assign snake  = snake_q;
    assign eat    = eat_q;
    assign dead   = dead_q;
    assign len    = len_q;
    assign head_x = seg_x_q[0];
    assign head_y = seg_y_q[0];

endmodule

// File: tb/tb_snake_body_ctrl.sv
`timescale 1ns/1ps
// tb_snake_body_ctrl: table vectors, hand sequences for the multi-cycle corners, then random
// stimulus against a queue-based model of the snake.
module tb_snake_body_ctrl;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int WALLE = WRAP ? 0 : 3;
    localparam int DX[4]  = '{0, 0, -1, 1};
    localparam int DY[4]  = '{-1, 1, 0, 0};
    localparam int OPP[4] = '{1, 0, 3, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        move_tick = 1'b0;
    logic [1:0]  dir = 2'b11;
    logic [5:0]  apple_x = 6'd20;
    logic [4:0]  apple_y = 5'd3;
    logic [11:0] x_pos = 12'd0;
    logic [11:0] y_pos = 12'd0;
    logic [1:0]  snake;
    logic        eat;
    logic        dead;
    logic [4:0]  len;
    logic [5:0]  head_x;
    logic [4:0]  head_y;

    int n_vec = 0;
    int n_miss = 0;

    int qx[$];
    int qy[$];
    int m_state;
    int m_dir;
    int e_snake;
    int e_eat;

    typedef struct {
        logic        st;
        logic        mv;
        logic [1:0]  d;
        logic [5:0]  ax;
        logic [4:0]  ay;
        logic [11:0] px;
        logic [11:0] py;
        int          e_snake;
        int          e_eat;
        int          e_dead;
        int          e_len;
        int          e_hx;
        int          e_hy;
    } vec_t;

    vec_t tbl[14];

    snake_body_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .move_tick(move_tick), .dir(dir),
        .apple_x(apple_x), .apple_y(apple_y), .x_pos(x_pos), .y_pos(y_pos),
        .snake(snake), .eat(eat), .dead(dead), .len(len), .head_x(head_x), .head_y(head_y)
    );

    always #5 clk = ~clk;

    // Model: snake as a queue of cells, head first.
    task automatic modelReset();
        qx.delete();
        qy.delete();
        for (int k = 0; k < 3; k++) begin
            qx.push_back(8 - k);
            qy.push_back(8);
        end
        m_dir = 3;
    endtask

    function automatic int classify(int px, int py);
        int cx;
        int cy;
        cx = px / 16;
        cy = py / 16;
        if (px >= 480 || py >= 272) return 0;
        if (!WRAP && (cx == 0 || cx == 29 || cy == 0 || cy == 16)) return 3;
        if (cx == qx[0] && cy == qy[0]) return 1;
        for (int k = 1; k < qx.size(); k++) begin
            if (cx == qx[k] && cy == qy[k]) return 2;
        end
        return 0;
    endfunction

    task automatic modelStep();
        int  nd;
        int  nx;
        int  ny;
        bit  grow;
        bit  hit;
        e_snake = classify(int'(x_pos), int'(y_pos));
        e_eat = 0;
        if (start) begin
            modelReset();
            m_state = 1;
        end else if (m_state == 1 && move_tick) begin
            nd = (int'(dir) == OPP[m_dir]) ? m_dir : int'(dir);
            nx = qx[0] + DX[nd];
            ny = qy[0] + DY[nd];
            if (WRAP) begin
                nx = (nx + 30) % 30;
                ny = (ny + 17) % 17;
            end
            grow = (nx == int'(apple_x)) && (ny == int'(apple_y));
            hit = !WRAP && (nx == 0 || nx == 29 || ny == 0 || ny == 16);
            for (int k = 0; k < qx.size(); k++) begin
                if ((k < qx.size() - 1 || grow) && qx[k] == nx && qy[k] == ny) hit = 1'b1;
            end
            if (hit) begin
                m_state = 2;
            end else begin
                qx.push_front(nx);
                qy.push_front(ny);
                m_dir = nd;
                if (!grow || qx.size() > 16) begin
                    void'(qx.pop_back());
                    void'(qy.pop_back());
                end
                e_eat = grow ? 1 : 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic mv, input logic [1:0] d,
                                 input logic [5:0] ax, input logic [4:0] ay,
                                 input logic [11:0] px, input logic [11:0] py, input bit use_model);
        start = st;
        move_tick = mv;
        dir = d;
        apple_x = ax;
        apple_y = ay;
        x_pos = px;
        y_pos = py;
        if (use_model) modelStep();
        @(posedge clk);
        #1;
        start = 1'b0;
        move_tick = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        start = 1'b0;
        move_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        m_state = 0;
        e_snake = 0;
        e_eat = 0;
    endtask

    task automatic tick(input logic [1:0] d, input logic [5:0] ax, input logic [4:0] ay);
        applyStimulus(1'b0, 1'b1, d, ax, ay, 12'd240, 12'd100, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd3, 6'd20, 5'd3, 12'd0,   12'd0,   WALLE, 0, 0, 3,  8, 8};
        tbl[1]  = '{1'b0, 1'b1, 2'd3, 6'd20, 5'd3, 12'd128, 12'd128, 1,     0, 0, 3,  9, 8};
        tbl[2]  = '{1'b0, 1'b1, 2'd3, 6'd20, 5'd3, 12'd128, 12'd128, 2,     0, 0, 3, 10, 8};
        tbl[3]  = '{1'b0, 1'b1, 2'd3, 6'd20, 5'd3, 12'd240, 12'd100, 0,     0, 0, 3, 11, 8};
        tbl[4]  = '{1'b0, 1'b0, 2'd3, 6'd20, 5'd3, 12'd176, 12'd128, 1,     0, 0, 3, 11, 8};
        tbl[5]  = '{1'b0, 1'b0, 2'd3, 6'd20, 5'd3, 12'd160, 12'd128, 2,     0, 0, 3, 11, 8};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 6'd20, 5'd3, 12'd500, 12'd10,  0,     0, 0, 3, 12, 8};
        tbl[7]  = '{1'b0, 1'b1, 2'd3, 6'd13, 5'd8, 12'd0,   12'd0,   WALLE, 1, 0, 4, 13, 8};
        tbl[8]  = '{1'b0, 1'b0, 2'd3, 6'd20, 5'd3, 12'd160, 12'd128, 2,     0, 0, 4, 13, 8};
        tbl[9]  = '{1'b0, 1'b1, 2'd0, 6'd20, 5'd3, 12'd96,  12'd128, 0,     0, 0, 4, 13, 7};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 6'd20, 5'd3, 12'd479, 12'd200, WALLE, 0, 0, 4, 13, 7};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 6'd20, 5'd3, 12'd200, 12'd271, WALLE, 0, 0, 4, 13, 7};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 6'd20, 5'd3, 12'd200, 12'd272, 0,     0, 0, 4, 13, 7};
        tbl[13] = '{1'b0, 1'b1, 2'd1, 6'd20, 5'd3, 12'd208, 12'd112, 1,     0, 0, 4, 13, 6};

        doReset();
        checkOutput("reset.snake", int'(snake), 0);
        checkOutput("reset.eat", int'(eat), 0);
        checkOutput("reset.dead", int'(dead), 0);
        checkOutput("reset.len", int'(len), 3);
        checkOutput("reset.head_x", int'(head_x), 8);
        checkOutput("reset.head_y", int'(head_y), 8);

        tick(2'd3, 6'd20, 5'd3);
        checkOutput("idle_tick.head_x", int'(head_x), 8);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].st, tbl[i].mv, tbl[i].d, tbl[i].ax, tbl[i].ay,
                          tbl[i].px, tbl[i].py, 1'b0);
            checkOutput($sformatf("vec%0d.snake", i), int'(snake), tbl[i].e_snake);
            checkOutput($sformatf("vec%0d.eat", i), int'(eat), tbl[i].e_eat);
            checkOutput($sformatf("vec%0d.dead", i), int'(dead), tbl[i].e_dead);
            checkOutput($sformatf("vec%0d.len", i), int'(len), tbl[i].e_len);
            checkOutput($sformatf("vec%0d.head_x", i), int'(head_x), tbl[i].e_hx);
            checkOutput($sformatf("vec%0d.head_y", i), int'(head_y), tbl[i].e_hy);
        end

        // Running into the right-hand border.
        doReset();
        applyStimulus(1'b1, 1'b0, 2'd3, 6'd20, 5'd3, 12'd0, 12'd0, 1'b0);
        repeat (20) tick(2'd3, 6'd20, 5'd3);
        checkOutput("wall.head_x_before", int'(head_x), 28);
`ifdef SNAKE_WRAP_EN
        tick(2'd3, 6'd20, 5'd3);
        tick(2'd3, 6'd20, 5'd3);
        checkOutput("wrap.head_x", int'(head_x), 0);
        checkOutput("wrap.head_y", int'(head_y), 8);
        checkOutput("wrap.dead", int'(dead), 0);
        applyStimulus(1'b0, 1'b0, 2'd3, 6'd20, 5'd3, 12'd0, 12'd0, 1'b0);
        checkOutput("wrap.pixel00", int'(snake), 0);
`else
        tick(2'd3, 6'd20, 5'd3);
        checkOutput("wall.dead", int'(dead), 1);
        checkOutput("wall.head_x", int'(head_x), 28);
        tick(2'd3, 6'd20, 5'd3);
        checkOutput("wall.dead_hold", int'(dead), 1);
        checkOutput("wall.head_x_hold", int'(head_x), 28);
        checkOutput("wall.len_hold", int'(len), 3);
`endif
        applyStimulus(1'b1, 1'b1, 2'd3, 6'd20, 5'd3, 12'd0, 12'd0, 1'b0);
        checkOutput("restart.dead", int'(dead), 0);
        checkOutput("restart.head_x", int'(head_x), 8);
        checkOutput("restart.len", int'(len), 3);

        // Grow to length 5, then a tight up/left/down turn bites the body.
        tick(2'd3, 6'd9, 5'd8);
        tick(2'd3, 6'd10, 5'd8);
        checkOutput("self.len5", int'(len), 5);
        tick(2'd0, 6'd20, 5'd3);
        tick(2'd2, 6'd20, 5'd3);
        tick(2'd1, 6'd20, 5'd3);
        checkOutput("self.dead", int'(dead), 1);
        checkOutput("self.head_x", int'(head_x), 9);
        checkOutput("self.head_y", int'(head_y), 7);

        // Length saturates at 16 while eat keeps pulsing.
        applyStimulus(1'b1, 1'b0, 2'd3, 6'd20, 5'd3, 12'd0, 12'd0, 1'b0);
        for (int k = 0; k < 14; k++) begin
            tick(2'd3, 6'(9 + k), 5'd8);
            checkOutput($sformatf("sat%0d.len", k), int'(len), (4 + k > 16) ? 16 : 4 + k);
            checkOutput($sformatf("sat%0d.eat", k), int'(eat), 1);
        end
        applyStimulus(1'b0, 1'b0, 2'd3, 6'd20, 5'd3, 12'd0, 12'd0, 1'b0);
        checkOutput("sat.eat_fall", int'(eat), 0);

        // Reset asserted while a tick is pending discards the move.
        move_tick = 1'b1;
        dir = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid.head_x_async", int'(head_x), 8);
        @(posedge clk);
        #1;
        rst = 1'b0;
        move_tick = 1'b0;
        checkOutput("rstmid.head_x", int'(head_x), 8);
        checkOutput("rstmid.len", int'(len), 3);
        checkOutput("rstmid.eat", int'(eat), 0);

        // Random stimulus against the model.
        doReset();
        for (int n = 0; n < 4000; n++) begin
            logic        st;
            logic        mv;
            logic [1:0]  d;
            logic [5:0]  ax;
            logic [4:0]  ay;
            logic [11:0] px;
            logic [11:0] py;
            int          k;
            int          ad;
            st = ($urandom_range(0, 199) == 0) || (m_state != 1 && $urandom_range(0, 5) == 0);
            mv = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_dir);
            if ($urandom_range(0, 2) == 0) begin
                ad = (int'(d) == OPP[m_dir]) ? m_dir : int'(d);
                ax = 6'(qx[0] + DX[ad]);
                ay = 5'(qy[0] + DY[ad]);
            end else begin
                ax = 6'($urandom_range(0, 29));
                ay = 5'($urandom_range(0, 16));
            end
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, qx.size() - 1);
                px = 12'(qx[k] * 16 + $urandom_range(0, 15));
                py = 12'(qy[k] * 16 + $urandom_range(0, 15));
            end else begin
                px = 12'($urandom_range(0, 599));
                py = 12'($urandom_range(0, 349));
            end
            applyStimulus(st, mv, d, ax, ay, px, py, 1'b1);
            checkOutput("rand.snake", int'(snake), e_snake);
            checkOutput("rand.eat", int'(eat), e_eat);
            checkOutput("rand.dead", int'(dead), (m_state == 2) ? 1 : 0);
            checkOutput("rand.len", int'(len), qx.size());
            checkOutput("rand.head_x", int'(head_x), qx[0]);
            checkOutput("rand.head_y", int'(head_y), qy[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
